// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: FSM states and SPI core register map shared by the stream bridge.
package spi_bridge_pkg;
  typedef enum logic [3:0] {
    INIT,
    IDLE,
    SSO_ON,
    WAIT_T,
    WR,
    WAIT_R,
    RD,
    NEXT,
    SSO_OFF
  } state_t;
  localparam logic [2:0] ADDR_RXDATA   = 3'd0;
  localparam logic [2:0] ADDR_TXDATA   = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_CONTROL  = 3'd3;
  localparam logic [2:0] ADDR_SLAVESEL = 3'd5;
  localparam int CTRL_SSO_BIT = 10;
  localparam logic [15:0] CTRL_SSO = 16'h0001 << CTRL_SSO_BIT;
endpackage

// File: rtl/spi_bridge_rx_fifo.sv
// spi_bridge_rx_fifo: small synchronous byte FIFO with a registered head.
module spi_bridge_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  always_comb begin
    out_valid = count != '0;
    full = count == (AW+1)'(DEPTH);
    do_push = push && !full;
    do_pop = pop && out_valid;
    out_data = mem[rd_ptr];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/spi_stream_bridge.sv
// spi_stream_bridge: streams TX bytes into the 8-bit SPI master core over its register port
// and returns received bytes through an RX FIFO, holding SS_n low for each packet.
module spi_stream_bridge
  import spi_bridge_pkg::*;
#(
  parameter int          RX_DEPTH   = 4,
  parameter logic [15:0] SLAVE_MASK = 16'h0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic        read_n,
  output logic        write_n,
  output logic [15:0] data_from_cpu,
  input  logic [15:0] data_to_cpu,
  input  logic        readyfordata,
  input  logic        dataavailable,
  output logic        busy
);
  state_t state, state_nxt;
  logic [1:0] ph, ph_nxt;
  logic last_q, acc, act, done, space, full, push, unused_hi;
  assign unused_hi = ^data_to_cpu[15:8];
  // Each access state spends ph=0 idle (the bus gap), then ph=1,2 with the strobe asserted.
  always_comb begin
    acc = state inside {INIT, SSO_ON, WR, RD, SSO_OFF};
    act = acc && ph != 2'd0;
    done = acc && ph == 2'd2;
    space = !full;
    ph_nxt = acc && !done ? ph + 2'd1 : 2'd0;
    state_nxt = state;
    case (state)
      INIT:    if (done) state_nxt = IDLE;
      IDLE:    if (in_valid && space) state_nxt = SSO_ON;
      SSO_ON:  if (done) state_nxt = WAIT_T;
      WAIT_T:  if (readyfordata) state_nxt = WR;
      WR:      if (done) state_nxt = WAIT_R;
      WAIT_R:  if (dataavailable) state_nxt = RD;
      RD:      if (done) state_nxt = NEXT;
      NEXT:    state_nxt = last_q ? SSO_OFF : in_valid && space ? WAIT_T : NEXT;
      SSO_OFF: if (done) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end
  always_comb begin
    spi_select = act;
    read_n = !(act && state == RD);
    write_n = !(act && state != RD);
    mem_addr = !act ? 3'd0 : state == INIT ? ADDR_SLAVESEL : state == WR ? ADDR_TXDATA :
               state == RD ? ADDR_RXDATA : ADDR_CONTROL;
    data_from_cpu = !act ? 16'h0000 : state == INIT ? SLAVE_MASK : state == SSO_ON ? CTRL_SSO :
                    state == WR ? {8'h00, in_data} : 16'h0000;
    in_ready = state == WR && done;
    push = state == RD && done;
    busy = !(state inside {INIT, IDLE});
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= INIT;
      ph <= 2'd0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ph <= ph_nxt;
      if (in_ready) last_q <= in_last;
    end
  spi_bridge_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (data_to_cpu[7:0]),
    .pop       (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .full      (full)
  );
endmodule

// File: tb/tb_spi_stream_bridge.sv
// tb_spi_stream_bridge: random packets through a bus-level SPI core model, checked against
// an expected register-access sequence and an RX byte scoreboard.
module tb_spi_stream_bridge;
  import spi_bridge_pkg::*;
  logic clk = 0, reset_n = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_last = 0, in_ready;
  logic [7:0] out_data;
  logic out_valid, out_ready = 0;
  logic spi_select, read_n, write_n, busy;
  logic [2:0] mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu = 16'hC300;
  logic readyfordata = 1, dataavailable = 0;

  spi_stream_bridge #(.RX_DEPTH(4), .SLAVE_MASK(16'h0001)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .spi_select(spi_select), .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .readyfordata(readyfordata),
    .dataavailable(dataavailable), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic l; int gap; } tx_t;
  tx_t tx_q[$];
  logic [19:0] bus_exp[$];
  logic [7:0] rx_exp[$];
  int checks = 0, errors = 0, n_tx = 0, n_rx = 0, allow_pops = -1, lat_lo = 1, lat_hi = 12;
  bit sync_pop = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] wrec(input logic [2:0] a, input logic [15:0] d);
    return {1'b0, a, d};
  endfunction

  task automatic pkt_start();
    bus_exp.push_back(wrec(ADDR_CONTROL, 16'h0400));
  endtask

  task automatic pkt_end();
    bus_exp.push_back(wrec(ADDR_CONTROL, 16'h0000));
  endtask

  task automatic add_byte(input logic [7:0] b, input logic l, input int gap);
    tx_t t;
    t.d = b; t.l = l; t.gap = gap;
    tx_q.push_back(t);
    bus_exp.push_back(wrec(ADDR_TXDATA, {8'h00, b}));
    bus_exp.push_back({1'b1, ADDR_RXDATA, 16'h0000});
    rx_exp.push_back(b);
  endtask

  task automatic rand_packet(input int len);
    pkt_start();
    for (int i = 0; i < len; i++)
      add_byte(8'($urandom), i == len - 1, $urandom_range(0, 5) == 0 ? 20 : $urandom_range(0, 3));
    pkt_end();
  endtask

  task automatic wait_done(input int budget, input bit need_rx);
    int k = 0;
    while (k < budget && !(tx_q.size() == 0 && bus_exp.size() == 0 && !busy &&
                           (!need_rx || rx_exp.size() == 0))) begin
      @(negedge clk); #1;
      k++;
    end
    check("done", 32'(k < budget), 1);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_spi_select", spi_select, 0);
    check("rst_read_n", read_n, 1);
    check("rst_write_n", write_n, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_data_from_cpu", data_from_cpu, 0);
    check("rst_busy", busy, 0);
  endtask

  // TX stream source: holds each byte until the handshake edge, with optional idle gaps.
  initial begin
    bit pend = 0, took;
    int gap_left = -1;
    tx_t t;
    forever begin
      @(negedge clk);
      took = pend;
      pend = 0;
      if (!reset_n) begin
        in_valid = 0;
        gap_left = -1;
      end else begin
        if (took && tx_q.size() > 0) begin
          t = tx_q.pop_front();
          in_valid = 0;
          in_data = 8'($urandom);
        end
        if (!in_valid && tx_q.size() > 0) begin
          if (gap_left < 0) gap_left = tx_q[0].gap;
          if (gap_left > 0) gap_left--;
          else begin
            in_valid = 1; in_data = tx_q[0].d; in_last = tx_q[0].l; gap_left = -1;
          end
        end
        pend = in_valid && in_ready;
      end
    end
  end

  // RX stream sink with a random, limited, or read-synchronised out_ready.
  initial begin
    int rd_run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        out_ready = 0;
        rd_run = 0;
      end else begin
        out_ready = sync_pop ? (spi_select && !read_n && rd_run == 1 && allow_pops != 0)
                             : (allow_pops != 0 && $urandom_range(0, 3) != 0);
        rd_run = (spi_select && !read_n) ? rd_run + 1 : 0;
        if (out_valid && out_ready) begin
          if (rx_exp.size() == 0) check("rx_extra", rx_exp.size(), 1);
          else check("rx_data", out_data, rx_exp.pop_front());
          n_rx++;
          if (allow_pops > 0) allow_pops--;
        end
      end
    end
  end

  // Bus monitor and SPI core model: loopback RX, TRDY/RRDY handshakes, SSO tracking.
  initial begin
    int run = 0, lat = 0;
    bit sso = 0, rd;
    logic [20:0] cur, held;
    logic [19:0] rec;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run = 0; lat = 0; sso = 0; readyfordata = 1; dataavailable = 0;
      end else begin
        if (lat > 0) begin
          lat--;
          if (lat == 0) dataavailable = 1;
        end
        if (spi_select) begin
          cur = {mem_addr, read_n, write_n, data_from_cpu};
          if (run == 0) begin
            held = cur;
            check("strobe_one", 32'(read_n ^ write_n), 1);
          end else check("bus_hold", cur, held);
          run++;
        end else begin
          check("bus_idle", {read_n, write_n}, 2'b11);
          if (run > 0) begin
            check("strobe_len", run, 2);
            rd = !held[17];
            rec = {rd, held[20:18], rd ? 16'h0000 : held[15:0]};
            if (bus_exp.size() == 0) check("bus_extra", {1'b0, rec}, 21'h1FFFFF);
            else check("bus_seq", rec, bus_exp.pop_front());
            if (!rd && held[20:18] == ADDR_CONTROL) sso = held[CTRL_SSO_BIT];
            if (!rd && held[20:18] == ADDR_TXDATA) begin
              check("tx_trdy", readyfordata, 1);
              check("tx_sso", sso, 1);
              check("tx_busy", busy, 1);
              readyfordata = 0;
              data_to_cpu = {8'($urandom), held[7:0]};
              lat = $urandom_range(lat_lo, lat_hi);
              n_tx++;
            end
            if (rd && held[20:18] == ADDR_RXDATA) begin
              check("rx_rrdy", dataavailable, 1);
              dataavailable = 0;
              readyfordata = 1;
            end
            run = 0;
          end
        end
      end
    end
  end

  initial begin
    int base, k;
    repeat (3) @(negedge clk);
    #1 check_reset_vals();
    bus_exp.push_back(wrec(ADDR_SLAVESEL, 16'h0001));
    @(negedge clk); #1 reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("init_in_ready", in_ready, 0);
      check("init_busy", busy, 0);
    end
    check("init_done", bus_exp.size(), 0);
    pkt_start(); add_byte(8'hA5, 0, 0); add_byte(8'h3C, 1, 0); pkt_end();
    wait_done(2000, 1);
    for (int p = 0; p < 12; p++) rand_packet($urandom_range(1, 6));
    wait_done(20000, 1);
    pkt_start();
    add_byte(8'h11, 0, 0); add_byte(8'h22, 0, 20); add_byte(8'h33, 0, 20); add_byte(8'h44, 1, 0);
    pkt_end();
    wait_done(3000, 1);
    allow_pops = 0;
    base = n_tx;
    rand_packet(6);
    repeat (300) @(negedge clk);
    #1;
    check("bp_sent", n_tx - base, 4);
    check("bp_busy", busy, 1);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    allow_pops = 1;
    repeat (200) @(negedge clk);
    #1 check("bp_fifth", n_tx - base, 5);
    allow_pops = -1;
    wait_done(3000, 1);
    allow_pops = 0;
    base = n_rx;
    rand_packet(2);
    wait_done(3000, 0);
    allow_pops = 1;
    sync_pop = 1;
    rand_packet(1);
    wait_done(3000, 0);
    check("sync_pops", n_rx - base, 1);
    check("sync_valid", out_valid, 1);
    sync_pop = 0;
    allow_pops = -1;
    wait_done(3000, 1);
    check("sync_total", n_rx - base, 3);
    lat_lo = 40; lat_hi = 40;
    base = n_tx;
    rand_packet(3);
    k = 0;
    while (n_tx == base && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    check("rst_wait", 32'(k < 500), 1);
    repeat (2) @(negedge clk);
    #1 reset_n = 0;
    #1 check_reset_vals();
    tx_q.delete(); bus_exp.delete(); rx_exp.delete();
    lat_lo = 1; lat_hi = 12;
    repeat (3) @(negedge clk);
    bus_exp.push_back(wrec(ADDR_SLAVESEL, 16'h0001));
    #1 reset_n = 1;
    for (int p = 0; p < 4; p++) rand_packet($urandom_range(1, 5));
    wait_done(10000, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
